// File: rtl/plane_pkg.sv
// Shared sizes, colour key and reset position for the player-plane renderer.
// Coordinates are 11 bits on the wire and widened to 12 bits for the hit test.
package plane_pkg;

  localparam int unsigned CoordW   = 11;
  localparam int unsigned ExtW     = 12;
  localparam int unsigned RgbW     = 12;
  localparam int unsigned ActW     = 1024;
  localparam int unsigned ActH     = 768;
  localparam int unsigned SprHalfW = 64;
  localparam int unsigned SprHalfH = 64;
  localparam int unsigned SprAddrW = 14;

  localparam logic [RgbW-1:0]   KeyRgb = 12'hF0F;
  localparam logic [CoordW-1:0] InitX  = 11'd400;
  localparam logic [CoordW-1:0] InitY  = 11'd512;

  typedef logic [CoordW-1:0] coord_t;
  typedef logic [ExtW-1:0]   ext_t;
  typedef logic [RgbW-1:0]   rgb_t;

  // Per-pixel side information carried alongside the ROM access.
  typedef struct packed {
    logic hit;
    logic de;
    rgb_t bg;
  } px_t;

  // Both bounds are offset by the half size, so no subtraction can underflow.
  function automatic logic in_span(input ext_t pos, input ext_t lo, input ext_t span);
    return (pos >= lo) && (pos < ext_t'(lo + span));
  endfunction

endpackage

// File: rtl/my_plane_render_edge.sv
// Two-flop falling-edge detector producing a registered one-cycle strobe.
// The history flop resets low so a level held high through reset never pulses.
module my_plane_render_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic fall_o
);

  logic sig_q, sig_d;
  logic fall_q, fall_d;

  always_comb begin
    sig_d  = sig_i;
    fall_d = sig_q & ~sig_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q  <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      fall_q <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/my_plane_render.sv
// Player-plane renderer: vsync strobe, per-frame position snapshot, sprite hit test,
// sprite ROM addressing and colour-keyed composite over background, 3-cycle pipeline.
module my_plane_render
  import plane_pkg::*;
#(
  parameter int unsigned HALF_W  = SprHalfW,
  parameter int unsigned HALF_H  = SprHalfH,
  parameter int unsigned ADDR_W  = SprAddrW,
  parameter logic [11:0] KEY_RGB = KeyRgb,
  parameter logic [10:0] INIT_X  = InitX,
  parameter logic [10:0] INIT_Y  = InitY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              de,
  input  logic [10:0]       hcnt,
  input  logic [10:0]       vcnt,
  input  logic [10:0]       plane_x,
  input  logic [10:0]       plane_y,
  input  logic [11:0]       bg_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              vs_neg,
  output logic [11:0]       rgb_out,
  output logic              de_out,
  output logic              hit_out
);

  localparam int unsigned ColW = $clog2(2 * HALF_W);
  localparam int unsigned RowW = $clog2(2 * HALF_H);

  logic              vs_neg_d_q, vs_neg_d_d;
  coord_t            frame_x_q, frame_x_d;
  coord_t            frame_y_q, frame_y_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  px_t               p1_q, p1_d;
  px_t               p2_q, p2_d;
  rgb_t              rgb_q, rgb_d;
  logic              hit_out_q, hit_out_d;
  logic              de_out_q, de_out_d;

  ext_t            hx, vy;
  logic            hit0;
  logic [ColW-1:0] col;
  logic [RowW-1:0] row;
  logic            opaque;

  my_plane_render_edge u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (vsync),
    .fall_o (vs_neg)
  );

  // Snapshot one cycle after the strobe so the controller's update is already visible.
  always_comb begin
    vs_neg_d_d = vs_neg;
    frame_x_d  = vs_neg_d_q ? plane_x : frame_x_q;
    frame_y_d  = vs_neg_d_q ? plane_y : frame_y_q;
  end

  // Stage 1: hit test and ROM address.
  always_comb begin
    hx   = ext_t'(hcnt) + ext_t'(HALF_W);
    vy   = ext_t'(vcnt) + ext_t'(HALF_H);
    hit0 = de
         & in_span(hx, ext_t'(frame_x_q), ext_t'(2 * HALF_W))
         & in_span(vy, ext_t'(frame_y_q), ext_t'(2 * HALF_H));
    col  = ColW'(hx - ext_t'(frame_x_q));
    row  = RowW'(vy - ext_t'(frame_y_q));
    rom_addr_d = hit0 ? ADDR_W'({row, col}) : '0;
    p1_d.hit   = hit0;
    p1_d.de    = de;
    p1_d.bg    = bg_rgb;
  end

  // Stage 2 runs in parallel with the ROM read.
  always_comb begin
    p2_d = p1_q;
  end

  // Stage 3: colour key and composite.
  always_comb begin
    opaque    = p2_q.hit & (rom_data != KEY_RGB);
    rgb_d     = !p2_q.de ? '0 : (opaque ? rom_data : p2_q.bg);
    hit_out_d = opaque & p2_q.de;
    de_out_d  = p2_q.de;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_neg_d_q <= 1'b0;
      frame_x_q  <= INIT_X;
      frame_y_q  <= INIT_Y;
      rom_addr_q <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      rgb_q      <= '0;
      hit_out_q  <= 1'b0;
      de_out_q   <= 1'b0;
    end else begin
      vs_neg_d_q <= vs_neg_d_d;
      frame_x_q  <= frame_x_d;
      frame_y_q  <= frame_y_d;
      rom_addr_q <= rom_addr_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      rgb_q      <= rgb_d;
      hit_out_q  <= hit_out_d;
      de_out_q   <= de_out_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rgb_out  = rgb_q;
  assign hit_out  = hit_out_q;
  assign de_out   = de_out_q;

endmodule

// File: tb/tb_my_plane_render.sv
// Randomised scoreboard bench for my_plane_render with a sprite-window reference model
// and a synchronous ROM model.
module tb_my_plane_render;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b1;
  logic        de = 1'b0;
  logic [10:0] hcnt = '0;
  logic [10:0] vcnt = '0;
  logic [10:0] plane_x = 11'd400;
  logic [10:0] plane_y = 11'd512;
  logic [11:0] bg_rgb = '0;
  logic [13:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        vs_neg;
  logic [11:0] rgb_out;
  logic        de_out;
  logic        hit_out;

  logic [11:0] mem [16384];

  typedef struct { int due; logic [13:0] addr; } aexp_t;
  typedef struct { int due; logic [11:0] rgb; logic hit; } pexp_t;
  aexp_t aq[$];
  pexp_t pq[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int fx = 400;
  int fy = 512;

  my_plane_render dut (
    .clk      (clk),
    .rst      (rst),
    .vsync    (vsync),
    .de       (de),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .plane_x  (plane_x),
    .plane_y  (plane_y),
    .bg_rgb   (bg_rgb),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .vs_neg   (vs_neg),
    .rgb_out  (rgb_out),
    .de_out   (de_out),
    .hit_out  (hit_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".vs_neg"}, 32'(vs_neg), 0);
    chk({tag, ".rom_addr"}, 32'(rom_addr), 0);
    chk({tag, ".rgb_out"}, 32'(rgb_out), 0);
    chk({tag, ".de_out"}, 32'(de_out), 0);
    chk({tag, ".hit_out"}, 32'(hit_out), 0);
  endtask

  function automatic int clip(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Reference: sprite occupies [fx-64, fx+63] x [fy-64, fy+63], ROM is row-major 128 wide.
  task automatic drive_px(input int hc, input int vc, input logic d, input logic [11:0] bg);
    int hx, vy, a;
    logic hit;
    aexp_t ae;
    pexp_t pe;
    @(posedge clk); #1;
    hcnt = 11'(hc);
    vcnt = 11'(vc);
    de = d;
    bg_rgb = bg;
    hx = hc + 64;
    vy = vc + 64;
    hit = d && hx >= fx && hx < fx + 128 && vy >= fy && vy < fy + 128;
    a = hit ? (vy - fy) * 128 + (hx - fx) : 0;
    ae.due = cyc + 1;
    ae.addr = 14'(a);
    aq.push_back(ae);
    if (d) begin
      pe.due = cyc + 3;
      pe.hit = hit && (mem[a] != 12'hF0F);
      pe.rgb = pe.hit ? mem[a] : bg;
      pq.push_back(pe);
    end
  endtask

  task automatic rand_px(input int n);
    for (int i = 0; i < n; i++) begin
      int hc, vc;
      hc = $urandom_range(0, 1) ? int'($urandom_range(0, 1023))
                                : clip(fx - 70 + int'($urandom_range(0, 140)), 1023);
      vc = $urandom_range(0, 1) ? int'($urandom_range(0, 767))
                                : clip(fy - 70 + int'($urandom_range(0, 140)), 767);
      if ($urandom_range(0, 7) == 0) plane_x = 11'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) plane_y = 11'($urandom_range(0, 767));
      drive_px(hc, vc, $urandom_range(0, 9) != 0, 12'($urandom));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      de = 1'b0;
    end
  endtask

  task automatic vsync_fall(input int nx, input int ny);
    @(posedge clk); #1;
    de = 1'b0;
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vsync = 1'b0;
    @(negedge clk);
    chk("vs_neg_before", 32'(vs_neg), 0);
    @(posedge clk); #1;
    plane_x = 11'(nx);
    plane_y = 11'(ny);
    @(negedge clk);
    chk("vs_neg_pulse", 32'(vs_neg), 1);
    @(negedge clk);
    chk("vs_neg_after", 32'(vs_neg), 0);
    repeat (3) @(posedge clk);
    #1;
    fx = nx;
    fy = ny;
  endtask

  // Monitor: ROM address is due one cycle after issue, pixels pop when de_out is shown.
  always @(negedge clk) begin
    if (!rst) begin
      if (aq.size() > 0 && aq[0].due == cyc) begin
        aexp_t ae;
        ae = aq.pop_front();
        chk("rom_addr", 32'(rom_addr), 32'(ae.addr));
      end
      if (de_out) begin
        if (pq.size() == 0) begin
          chk("spurious_de_out", 1, 0);
        end else begin
          pexp_t pe;
          pe = pq.pop_front();
          chk("latency", 32'(cyc), 32'(pe.due));
          chk("rgb_out", 32'(rgb_out), 32'(pe.rgb));
          chk("hit_out", 32'(hit_out), 32'(pe.hit));
        end
      end else begin
        chk("blank_rgb", 32'(rgb_out), 0);
        chk("blank_hit", 32'(hit_out), 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom);
    mem[0]     = 12'h123;
    mem[16383] = 12'h456;
    mem[8256]  = 12'hF0F;
    mem[8246]  = 12'h0A5;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("vs_neg_no_spurious", 32'(vs_neg), 0);
    end

    // Frame at the reset position (400,512).
    drive_px(336, 448, 1'b1, 12'h0AA);
    drive_px(463, 575, 1'b1, 12'h0BB);
    drive_px(464, 575, 1'b1, 12'h0CC);
    drive_px(335, 448, 1'b1, 12'h0DD);
    drive_px(400, 512, 1'b1, 12'h0EE);
    drive_px(400, 512, 1'b0, 12'h0FF);
    rand_px(200);

    vsync_fall(500, 300);
    rand_px(300);

    vsync_fall(10, 300);
    drive_px(0, 300, 1'b1, 12'h111);
    drive_px(1000, 300, 1'b1, 12'h222);
    rand_px(200);

    // Reset in the middle of an active line.
    for (int i = 0; i < 4; i++) drive_px(20 + i, 310, 1'b1, 12'h333);
    @(posedge clk); #1;
    rst = 1'b1;
    aq.delete();
    pq.delete();
    @(negedge clk);
    chk_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    de = 1'b0;
    plane_x = 11'd700;
    plane_y = 11'd100;
    fx = 400;
    fy = 512;
    drive_px(336, 448, 1'b1, 12'h444);
    rand_px(150);

    idle(6);
    chk("drain_addr", 32'(aq.size()), 0);
    chk("drain_pix", 32'(pq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
